// File: rtl/md_unit.sv
// MIPS HI/LO multiply/divide unit: mult/multu/div/divu, mthi/mtlo.
// Latency: MULT_CYCLES / DIV_CYCLES edges from accept to HI/LO update; mthi/mtlo take effect on the accepting edge.
// Backpressure: Busy high while an op is in flight; every Start seen while busy is dropped, so upstream must stall.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [2:0]      r_op;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic            w_accept;
    logic            w_done;
    logic            w_mthi;
    logic            w_mtlo;
    logic            w_wr;
    logic [31:0]     w_res_hi;
    logic [31:0]     w_res_lo;

    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic               w_ovf;
    logic        [31:0] w_sdiv_b;
    logic        [31:0] w_udiv_b;
    logic signed [31:0] w_squo;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquo;
    logic        [31:0] w_urem;

    assign w_smul = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_umul = {32'd0, r_a} * {32'd0, r_b};

    // Divisors are forced to 1 for /0 (result discarded) and for INT_MIN/-1,
    // where INT_MIN/1 already yields the architected quotient and zero remainder.
    assign w_ovf    = (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_sdiv_b = ((r_b == 32'd0) || w_ovf) ? 32'd1 : r_b;
    assign w_udiv_b = (r_b == 32'd0) ? 32'd1 : r_b;
    assign w_squo   = $signed(r_a) / $signed(w_sdiv_b);
    assign w_srem   = $signed(r_a) % $signed(w_sdiv_b);
    assign w_uquo   = r_a / w_udiv_b;
    assign w_urem   = r_a % w_udiv_b;

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_wr     = 1'b0;
        case (r_op)
            3'd1: begin w_res_hi = w_smul[63:32]; w_res_lo = w_smul[31:0]; w_wr = 1'b1; end
            3'd2: begin w_res_hi = w_umul[63:32]; w_res_lo = w_umul[31:0]; w_wr = 1'b1; end
            3'd3: begin w_res_hi = w_srem;        w_res_lo = w_squo;       w_wr = (r_b != 32'd0); end
            3'd4: begin w_res_hi = w_urem;        w_res_lo = w_uquo;       w_wr = (r_b != 32'd0); end
            default: ;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    if ((MDOp >= 3'd1) && (MDOp <= 3'd4)) begin
                        w_accept = 1'b1;
                        w_next   = S_RUN;
                    end
                    w_mthi = (MDOp == 3'd5);
                    w_mtlo = (MDOp == 3'd6);
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_op  <= MDOp;
                r_cnt <= (MDOp <= 3'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
            if (w_done && w_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end
    end

    assign Busy = (r_cnt != '0);
    assign HI   = r_hi;
    assign LO   = r_lo;
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits in the execute stage beside the ALU and is fed the same two GRF read operands (RD1 → A, RD2 → B). It performs mult/multu/div/divu over a fixed number of cycles, signalling progress on Busy. It also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo through the RegSrc mux.

## Interface
- MULT_CYCLES, 5: cycles Busy stays high for mult/multu; must be ≥1.
- DIV_CYCLES, 10: cycles Busy stays high for div/divu; must be ≥1.

- Clk  in  1  clock, rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled on the rising edge of Clk.
- MDOp  in  3  operation selector: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- A  in  32  operand rs; dividend for div/divu; source for mthi/mtlo.
- B  in  32  operand rt; divisor for div/divu.
- Busy  out  1  high while a mult/div is in flight.
- HI  out  32  HI register, driven directly from a flop.
- LO  out  32  LO register, driven directly from a flop.

## Operation
- State is an idle/run state, a cycle counter (width ≥ clog2(DIV_CYCLES+1)), latched A, B and op, and the HI and LO flops.
- **Busy = (counter != 0).**
- **Idle, Start=1, MDOp 1–4:**
  - Latch A, B and op.
  - Load the counter with MULT_CYCLES (ops 1–2) or DIV_CYCLES (ops 3–4).
- **Idle, Start=1, MDOp 5:** HI ← A on the same edge. Busy stays low.
- **Idle, Start=1, MDOp 6:** LO ← A on the same edge. Busy stays low.
- **MDOp 0 or 7, or Start=0:** no effect.
- **Start while Busy=1:** ignored entirely, including mthi/mtlo. Latched operands are not disturbed. Upstream stall logic must hold the instruction until Busy=0.
- **Run:** counter decrements each edge. On the 1→0 edge, HI/LO ← result computed from the latched operands.
- **Arithmetic rules:**
  - mult: {HI,LO} = signed(A) × signed(B), 64-bit.
  - multu: {HI,LO} = unsigned(A) × unsigned(B), 64-bit.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
  - div overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - divu: unsigned quotient → LO, unsigned remainder → HI.
  - div or divu with B=0: the operation still runs DIV_CYCLES with Busy high; HI and LO keep their prior values.
- The result may be computed combinationally from the latched operands or iteratively. Only the visible timing below is mandated.

## Timing
- **Reset (Reset=0), asynchronous:** HI=0, LO=0, counter=0, Busy=0, latched operands=0. No other output exists.
- **Reset during a run:** the result is discarded and Busy drops immediately.
- **mult/div latency:** Start accepted at edge T.
  - Busy=1 from after T through the cycle before edge T+N (N = MULT_CYCLES or DIV_CYCLES).
  - At edge T+N, HI/LO update and Busy falls together.
  - HI/LO keep their old values until edge T+N.
- **Back-to-back:** a new Start is accepted on edge T+N itself only if Busy was already 0 before that edge. In practice the earliest new acceptance is edge T+N+1.
  - Exception: with N=1, Busy is high for exactly one cycle. A Start at edge T+1 is rejected because Busy=1 in the cycle preceding that edge.
- **mthi/mtlo:** zero latency. The new value is visible on HI/LO right after the accepting edge.
- **Bypassing:** none; HI/LO outputs are pure register reads.

## Test plan
- **Reset then mult:** Reset low → HI=LO=0, Busy=0. Then mult, A=0xFFFFFFFD (−3), B=5 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. Busy falls on the same edge HI/LO update.
- **multu:** A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. HI/LO unchanged at cycles 1–4.
- **div sign rules:** A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Then divu 7 / 0 with prior HI/LO=0x11111111/0x22222222 → Busy high 10 cycles, HI/LO unchanged.
- **Ignored requests while busy:** start div, then on cycle 3 pulse Start with mult (A=2, B=3), and on cycle 4 with mthi (A=0xDEADBEEF) → only the original div result appears, Busy stays high exactly 10 cycles, HI≠0xDEADBEEF.
- **mthi/mtlo when idle:** mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive edges → HI and LO reflect each value one edge after it is applied, with Busy 0 throughout.
- **Reset mid-operation:** assert Reset low during cycle 3 of a mult → Busy, HI and LO go to 0 immediately. After release, a new multu 3×4 completes normally: LO=12, HI=0 after 5 cycles.
